// File: rtl/snake_body_engine.sv
// Snake body tracker: shift-register segment array advanced on MOVE_TICK, with
// growth, edge handling, reversal rejection, sequential self-collision scan and pixel queries.
module snake_body_engine #(
   parameter int unsigned H_CELLS   = 160,
   parameter int unsigned V_CELLS   = 120,
   parameter int unsigned X_W       = 8,
   parameter int unsigned Y_W       = 7,
   parameter int unsigned MAX_LEN   = 32,
   parameter int unsigned INIT_LEN  = 4,
   parameter int unsigned WRAP_MODE = 0
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic                         START,
   input  logic                         MOVE_TICK,
   input  logic [1:0]                   DIR,
   input  logic [X_W-1:0]               TARGET_X,
   input  logic [Y_W-1:0]               TARGET_Y,
   input  logic [X_W-1:0]               QUERY_X,
   input  logic [Y_W-1:0]               QUERY_Y,
   output logic                         QUERY_HIT,
   output logic                         QUERY_HEAD,
   output logic [X_W-1:0]               HEAD_X,
   output logic [Y_W-1:0]               HEAD_Y,
   output logic [$clog2(MAX_LEN+1)-1:0] LENGTH,
   output logic                         TARGET_REACHED,
   output logic                         HIT_WALL,
   output logic                         HIT_SELF,
   output logic                         ALIVE,
   output logic                         BUSY
);

   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
   localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_SCAN, S_COMMIT, S_DEAD} state_e;

   state_e             state_q, state_d;
   logic [X_W-1:0]     seg_x_q [MAX_LEN];
   logic [X_W-1:0]     seg_x_d [MAX_LEN];
   logic [Y_W-1:0]     seg_y_q [MAX_LEN];
   logic [Y_W-1:0]     seg_y_d [MAX_LEN];
   logic [LEN_W-1:0]   len_q, len_d;
   logic [1:0]         heading_q, heading_d;
   logic [X_W-1:0]     next_x_q, next_x_d;
   logic [Y_W-1:0]     next_y_q, next_y_d;
   logic               eat_q, eat_d;
   logic [LEN_W-1:0]   scan_n_q, scan_n_d;
   logic [IDX_W-1:0]   scan_k_q, scan_k_d;
   logic               hit_wall_q, hit_wall_d;
   logic               hit_self_q, hit_self_d;
   logic               tr_q, tr_d;
   logic               qhit_q, qhit_d;
   logic               qhead_q, qhead_d;
   logic               alive_q, alive_d;
   logic               busy_q, busy_d;

   logic [1:0]         hd_sel_c;
   logic [X_W-1:0]     nx_c;
   logic [Y_W-1:0]     ny_c;
   logic               edge_exit_c, wall_c, eat_c, match_c, last_c, start_ok_c;
   logic [LEN_W-1:0]   scan_n_c;

   // Next head cell from the requested heading; a reversal keeps the old heading.
   always_comb begin
      hd_sel_c    = (DIR == (heading_q ^ 2'd2)) ? heading_q : DIR;
      nx_c        = seg_x_q[0];
      ny_c        = seg_y_q[0];
      edge_exit_c = 1'b0;
      case (hd_sel_c)
         2'd0: if (ny_c == '0) begin edge_exit_c = 1'b1; ny_c = Y_W'(V_CELLS - 1); end
               else ny_c = ny_c - Y_W'(1);
         2'd1: if (nx_c == X_W'(H_CELLS - 1)) begin edge_exit_c = 1'b1; nx_c = '0; end
               else nx_c = nx_c + X_W'(1);
         2'd2: if (ny_c == Y_W'(V_CELLS - 1)) begin edge_exit_c = 1'b1; ny_c = '0; end
               else ny_c = ny_c + Y_W'(1);
         default: if (nx_c == '0) begin edge_exit_c = 1'b1; nx_c = X_W'(H_CELLS - 1); end
                  else nx_c = nx_c - X_W'(1);
      endcase
      wall_c     = edge_exit_c && (WRAP_MODE == 0);
      eat_c      = (nx_c == TARGET_X) && (ny_c == TARGET_Y);
      // The tail vacates its cell unless the snake grows, so it is excluded from the scan.
      scan_n_c   = eat_c ? len_q : len_q - LEN_W'(1);
      match_c    = (next_x_q == seg_x_q[scan_k_q]) && (next_y_q == seg_y_q[scan_k_q]);
      last_c     = (LEN_W'(scan_k_q) + LEN_W'(1)) == scan_n_q;
      start_ok_c = START && ((state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_DEAD));
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (START) state_d = S_RUN;
         S_RUN:    if (START) state_d = S_RUN;
                   else if (MOVE_TICK) state_d = S_STEP;
         S_STEP:   if (wall_c) state_d = S_DEAD;
                   else if (scan_n_c == '0) state_d = S_COMMIT;
                   else state_d = S_SCAN;
         S_SCAN:   if (match_c) state_d = S_DEAD;
                   else if (last_c) state_d = S_COMMIT;
         S_COMMIT: state_d = S_RUN;
         S_DEAD:   if (START) state_d = S_RUN;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      seg_x_d    = seg_x_q;
      seg_y_d    = seg_y_q;
      len_d      = len_q;
      heading_d  = heading_q;
      next_x_d   = next_x_q;
      next_y_d   = next_y_q;
      eat_d      = eat_q;
      scan_n_d   = scan_n_q;
      scan_k_d   = scan_k_q;
      hit_wall_d = hit_wall_q;
      hit_self_d = hit_self_q;
      tr_d       = 1'b0;
      qhit_d     = 1'b0;
      qhead_d    = 1'b0;

      if (start_ok_c) begin
         for (int i = 0; i < int'(MAX_LEN); i++) begin
            seg_x_d[i] = (i < int'(INIT_LEN)) ? X_W'(int'(H_CELLS / 2) - i) : '0;
            seg_y_d[i] = (i < int'(INIT_LEN)) ? Y_W'(V_CELLS / 2) : '0;
         end
         len_d      = LEN_W'(INIT_LEN);
         heading_d  = 2'd1;
         hit_wall_d = 1'b0;
         hit_self_d = 1'b0;
      end

      case (state_q)
         S_STEP: begin
            heading_d = hd_sel_c;
            if (wall_c) hit_wall_d = 1'b1;
            next_x_d = nx_c;
            next_y_d = ny_c;
            eat_d    = eat_c;
            scan_n_d = scan_n_c;
            scan_k_d = '0;
         end
         S_SCAN: begin
            if (match_c) hit_self_d = 1'b1;
            else scan_k_d = scan_k_q + IDX_W'(1);
         end
         S_COMMIT: begin
            for (int i = 1; i < int'(MAX_LEN); i++) begin
               seg_x_d[i] = seg_x_q[i-1];
               seg_y_d[i] = seg_y_q[i-1];
            end
            seg_x_d[0] = next_x_q;
            seg_y_d[0] = next_y_q;
            if (eat_q) begin
               tr_d = 1'b1;
               if (len_q < LEN_W'(MAX_LEN)) len_d = len_q + LEN_W'(1);
            end
         end
         default: ;
      endcase

      // Pixel query over the currently valid segments
      if (state_q != S_IDLE) begin
         for (int i = 0; i < int'(MAX_LEN); i++) begin
            if ((LEN_W'(i) < len_q) && (seg_x_q[i] == QUERY_X) && (seg_y_q[i] == QUERY_Y))
               qhit_d = 1'b1;
         end
         qhead_d = (len_q != '0) && (seg_x_q[0] == QUERY_X) && (seg_y_q[0] == QUERY_Y);
      end

      alive_d = (state_d == S_RUN) || (state_d == S_STEP) ||
                (state_d == S_SCAN) || (state_d == S_COMMIT);
      busy_d  = (state_d == S_STEP) || (state_d == S_SCAN) || (state_d == S_COMMIT);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= S_IDLE;
         for (int i = 0; i < int'(MAX_LEN); i++) begin
            seg_x_q[i] <= '0;
            seg_y_q[i] <= '0;
         end
         len_q      <= '0;
         heading_q  <= 2'd1;
         next_x_q   <= '0;
         next_y_q   <= '0;
         eat_q      <= 1'b0;
         scan_n_q   <= '0;
         scan_k_q   <= '0;
         hit_wall_q <= 1'b0;
         hit_self_q <= 1'b0;
         tr_q       <= 1'b0;
         qhit_q     <= 1'b0;
         qhead_q    <= 1'b0;
         alive_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         seg_x_q    <= seg_x_d;
         seg_y_q    <= seg_y_d;
         len_q      <= len_d;
         heading_q  <= heading_d;
         next_x_q   <= next_x_d;
         next_y_q   <= next_y_d;
         eat_q      <= eat_d;
         scan_n_q   <= scan_n_d;
         scan_k_q   <= scan_k_d;
         hit_wall_q <= hit_wall_d;
         hit_self_q <= hit_self_d;
         tr_q       <= tr_d;
         qhit_q     <= qhit_d;
         qhead_q    <= qhead_d;
         alive_q    <= alive_d;
         busy_q     <= busy_d;
      end
   end

   assign QUERY_HIT      = qhit_q;
   assign QUERY_HEAD     = qhead_q;
   assign HEAD_X         = seg_x_q[0];
   assign HEAD_Y         = seg_y_q[0];
   assign LENGTH         = len_q;
   assign TARGET_REACHED = tr_q;
   assign HIT_WALL       = hit_wall_q;
   assign HIT_SELF       = hit_self_q;
   assign ALIVE          = alive_q;
   assign BUSY           = busy_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine: a wall-mode and a wrap-mode instance driven in lockstep.
module tb_snake_body_engine;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       tick = 1'b0;
   logic [1:0] dir = 2'd1;
   logic [7:0] tgt_x = 8'd200;
   logic [6:0] tgt_y = 7'd0;
   logic [7:0] qx = 8'd0;
   logic [6:0] qy = 7'd0;

   logic       qhit0, qhead0, tr0, hw0, hs0, alive0, busy0;
   logic [7:0] hx0;
   logic [6:0] hy0;
   logic [5:0] len0;
   logic       qhit1, qhead1, tr1, hw1, hs1, alive1, busy1;
   logic [7:0] hx1;
   logic [6:0] hy1;
   logic [5:0] len1;

   int errors = 0;
   int checks = 0;
   int lat;
   int trc;

   always #5 clk = ~clk;

   snake_body_engine #(.WRAP_MODE(0)) dut0 (
      .CLK(clk), .RESET(rst_n), .START(start), .MOVE_TICK(tick), .DIR(dir),
      .TARGET_X(tgt_x), .TARGET_Y(tgt_y), .QUERY_X(qx), .QUERY_Y(qy),
      .QUERY_HIT(qhit0), .QUERY_HEAD(qhead0), .HEAD_X(hx0), .HEAD_Y(hy0),
      .LENGTH(len0), .TARGET_REACHED(tr0), .HIT_WALL(hw0), .HIT_SELF(hs0),
      .ALIVE(alive0), .BUSY(busy0));

   snake_body_engine #(.WRAP_MODE(1)) dut1 (
      .CLK(clk), .RESET(rst_n), .START(start), .MOVE_TICK(tick), .DIR(dir),
      .TARGET_X(tgt_x), .TARGET_Y(tgt_y), .QUERY_X(qx), .QUERY_Y(qy),
      .QUERY_HIT(qhit1), .QUERY_HEAD(qhead1), .HEAD_X(hx1), .HEAD_Y(hy1),
      .LENGTH(len1), .TARGET_REACHED(tr1), .HIT_WALL(hw1), .HIT_SELF(hs1),
      .ALIVE(alive1), .BUSY(busy1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   // One move: edges counted from the tick-sampling edge until both instances go idle.
   task automatic move(input logic [1:0] d, output int edges, output int pulses);
      dir = d;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      edges = 0;
      pulses = 0;
      while ((busy0 || busy1) && edges < 100) begin
         cyc();
         edges++;
         if (tr0) pulses++;
      end
      if (edges >= 100) chk("move_timeout", 32'(edges), 32'd0);
   endtask

   initial begin
      // Reset state
      cyc();
      cyc();
      chk("rst_len", 32'(len0), 0);
      chk("rst_alive", 32'(alive0), 0);
      chk("rst_busy", 32'(busy0), 0);
      chk("rst_hx", 32'(hx0), 0);
      chk("rst_walls", 32'({hw0, hs0}), 0);
      rst_n = 1'b1;
      cyc();
      cyc();
      chk("idle_qhit", 32'(qhit0), 0);

      pulse_start();
      chk("start_len", 32'(len0), 4);
      chk("start_head", 32'({hx0, hy0}), 32'({8'd80, 7'd60}));
      chk("start_alive", 32'(alive0), 1);
      chk("start_busy", 32'(busy0), 0);

      qx = 8'd77; qy = 7'd60; cyc();
      chk("q77_hit", 32'({qhit0, qhead0}), 32'(2'b10));
      qx = 8'd76; cyc();
      chk("q76_hit", 32'({qhit0, qhead0}), 0);
      qx = 8'd80; cyc();
      chk("q80_head", 32'({qhit0, qhead0}), 32'(2'b11));

      // Plain move: scan of 3, latency 5 edges after the tick edge
      move(2'd1, lat, trc);
      chk("mv1_lat", 32'(lat), 5);
      chk("mv1_head", 32'({hx0, hy0}), 32'({8'd81, 7'd60}));
      chk("mv1_len", 32'(len0), 4);
      chk("mv1_tr", 32'(trc), 0);

      // Eating move: scan of 4, growth to 5, single pulse
      tgt_x = 8'd82; tgt_y = 7'd60;
      move(2'd1, lat, trc);
      chk("eat_lat", 32'(lat), 6);
      chk("eat_head", 32'({hx0, hy0}), 32'({8'd82, 7'd60}));
      chk("eat_len", 32'(len0), 5);
      chk("eat_tr_cnt", 32'(trc), 1);
      cyc();
      chk("eat_tr_low", 32'(tr0), 0);
      tgt_x = 8'd200; tgt_y = 7'd0;

      move(2'd3, lat, trc);
      chk("rev_head", 32'({hx0, hy0}), 32'({8'd83, 7'd60}));

      for (int i = 0; i < 76; i++) move(2'd1, lat, trc);
      chk("edge_hx0", 32'(hx0), 159);
      chk("edge_hx1", 32'(hx1), 159);

      move(2'd1, lat, trc);
      chk("wall_hw", 32'(hw0), 1);
      chk("wall_alive", 32'(alive0), 0);
      chk("wall_hx", 32'(hx0), 159);
      chk("wall_hs", 32'(hs0), 0);
      chk("wrap_hx", 32'({hx1, hy1}), 32'({8'd0, 7'd60}));
      chk("wrap_alive", 32'({alive1, hw1}), 32'(2'b10));

      move(2'd1, lat, trc);
      chk("dead_hx", 32'(hx0), 159);
      chk("dead_busy", 32'({alive0, busy0}), 0);
      chk("wrap_hx2", 32'(hx1), 1);

      // Restart from DEAD; closed 2x2 loop into the vacating tail
      pulse_start();
      chk("restart_hw", 32'({hw0, alive0}), 32'(2'b01));
      move(2'd0, lat, trc);
      move(2'd3, lat, trc);
      move(2'd2, lat, trc);
      move(2'd1, lat, trc);
      chk("loop_head", 32'({hx0, hy0}), 32'({8'd80, 7'd60}));
      chk("loop_alive", 32'({alive0, hs0}), 32'(2'b10));

      // Restart from RUN; grow to 5 then turn back into the body
      pulse_start();
      tgt_x = 8'd81; tgt_y = 7'd60;
      move(2'd1, lat, trc);
      chk("pre_len", 32'(len0), 5);
      tgt_x = 8'd200; tgt_y = 7'd0;
      move(2'd0, lat, trc);
      move(2'd3, lat, trc);
      move(2'd2, lat, trc);
      chk("self_hs", 32'(hs0), 1);
      chk("self_alive", 32'({alive0, hw0}), 0);
      chk("self_head", 32'({hx0, hy0}), 32'({8'd80, 7'd59}));
      chk("self_len", 32'(len0), 5);

      // START and tick together: START wins
      pulse_start();
      start = 1'b1; tick = 1'b1;
      cyc();
      start = 1'b0; tick = 1'b0;
      chk("both_busy", 32'(busy0), 0);
      chk("both_head", 32'({hx0, hy0, len0}), 32'({8'd80, 7'd60, 6'd4}));

      // Asynchronous reset in the middle of a scan
      dir = 2'd1; tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
      cyc();
      chk("scan_busy", 32'(busy0), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_outs", 32'({len0, alive0, busy0, hx0}), 0);
      cyc();
      rst_n = 1'b1;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
      cyc();
      chk("post_rst_tick", 32'({len0, alive0, busy0, hx0}), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
